data_buffer: RTL and testbench
==============================

DATA_BUFFER -- requirements
Module: data_buffer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and n_rst; n_rst is asserted high despite its name.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  asynchronous reset, active-high.
REQ-004 rx_packet_data  input  8  byte from USB RX to store.
REQ-005 store_rx_packet_data  input  1  write strobe, one byte per cycle while high.
REQ-006 get_rx_data  input  1  read strobe, one byte per cycle while high.
REQ-007 flush  input  1  synchronous empty request from RX side.
REQ-008 clear  input  1  synchronous empty request from host side.
REQ-009 rx_data  output  8  registered byte most recently popped.
REQ-010 buffer_occupancy  output  7  bytes currently stored, 0..64.

Function
REQ-011 SHALL be a 64-entry x 8-bit circular FIFO with 6-bit read and write pointers wrapping 63->0.
REQ-012 Store, when not full: mem[wr_ptr] <= rx_packet_data; wr_ptr+1; occupancy+1, all on the same edge.
REQ-013 Get, when not empty: rx_data <= mem[rd_ptr]; rd_ptr+1; occupancy-1; rx_data is valid the cycle after the strobe (1-cycle latency).
REQ-014 Store when full (occupancy 64) SHALL be ignored; data, pointers and occupancy unchanged.
REQ-015 Get when empty SHALL be ignored; rx_data holds its last value.
REQ-016 Simultaneous store and get, not empty and not full: both performed; occupancy unchanged.
REQ-017 Simultaneous store and get when empty: store only; get ignored; occupancy becomes 1.
REQ-018 Simultaneous store and get when full: both performed; read returns the old head entry; occupancy stays 64.
REQ-019 flush SHALL zero both pointers and occupancy on the next edge; rx_data holds.
REQ-020 clear SHALL zero both pointers, occupancy and rx_data on the next edge.
REQ-021 flush or clear SHALL take priority over store and get in the same cycle.
REQ-022 Memory contents need not be cleared by flush, clear or reset; stale entries are never readable.
REQ-023 buffer_occupancy SHALL be a registered count, never exceeding 64 and never underflowing.

Reset
REQ-024 While n_rst is high: rx_data = 0, buffer_occupancy = 0, and both pointers = 0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL discard all buffered data; the first store after release writes entry 0.

Structure
REQ-026 A shared package SHALL hold DEPTH=64, WIDTH=8, PTR_W=6 and OCC_W=7.
REQ-027 Storage SHALL be a sub-module data_buffer_mem (synchronous write, combinational read, 64x8); pointer, count and priority logic stay in data_buffer.

Verification
REQ-028 Power-on reset: n_rst high for 2 cycles, then low -> rx_data=0x00, buffer_occupancy=0.
REQ-029 Store 0xA5, 0x3C, then get twice -> occupancy 1, 2, 1, 0; rx_data 0xA5, then 0x3C, each one cycle after its get.
REQ-030 Store 64 bytes 0x00..0x3F, then store 0xFF -> occupancy stays 64; 64 gets return 0x00..0x3F in order, with no 0xFF.
REQ-031 Get on an empty buffer after reading 0x3F -> occupancy 0, rx_data stays 0x3F.
REQ-032 Fill with 10 bytes, assert flush -> occupancy 0 and rx_data unchanged; refill with 10 bytes and assert clear -> occupancy 0 and rx_data 0x00.
REQ-033 With occupancy 5, store and get together for 3 cycles -> occupancy stays 5 and FIFO order is preserved across the 63->0 pointer wrap.

Source files
------------

// File: rtl/data_buffer_pkg.sv
// Shared sizing and helper types for the 64x8 RX data buffer.
package data_buffer_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned PTR_W = 6;
  localparam int unsigned OCC_W = 7;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [WIDTH-1:0] data_t;
  typedef logic [OCC_W-1:0] occ_t;

  // Power-of-two depth, so the natural 6-bit rollover gives the 63->0 wrap.
  function automatic ptr_t ptr_inc(ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/data_buffer_mem.sv
// 64x8 storage array: synchronous write, combinational read, no reset.
module data_buffer_mem
  import data_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_buffer.sv
// Circular 64-entry RX byte FIFO with registered read data and occupancy count.
module data_buffer
  import data_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] rx_packet_data,
  input  logic             store_rx_packet_data,
  input  logic             get_rx_data,
  input  logic             flush,
  input  logic             clear,
  output logic [WIDTH-1:0] rx_data,
  output logic [OCC_W-1:0] buffer_occupancy
);

  ptr_t  wr_ptr_q;
  ptr_t  rd_ptr_q;
  data_t rd_data;
  logic  full;
  logic  empty;
  logic  do_get;
  logic  do_store;

  assign full  = (buffer_occupancy == occ_t'(DEPTH));
  assign empty = (buffer_occupancy == '0);

  // A store into a full buffer is allowed only when a get frees the head on the same edge;
  // since wr_ptr == rd_ptr when full, the combinational read still sees the old head.
  assign do_get   = get_rx_data && !empty;
  assign do_store = store_rx_packet_data && (!full || do_get);

  data_buffer_mem u_mem (
    .clk     (clk),
    .we      (do_store && !flush && !clear),
    .wr_addr (wr_ptr_q),
    .wr_data (rx_packet_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      buffer_occupancy <= '0;
      rx_data          <= '0;
    end else if (clear) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      buffer_occupancy <= '0;
      rx_data          <= '0;
    end else if (flush) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      buffer_occupancy <= '0;
    end else begin
      if (do_store) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_get) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        rx_data  <= rd_data;
      end
      buffer_occupancy <= buffer_occupancy + occ_t'(do_store) - occ_t'(do_get);
    end
  end

endmodule

// File: tb/tb_data_buffer.sv
// Scoreboarded bench for data_buffer: directed scenarios followed by randomized traffic.
module tb_data_buffer;

  logic       tb_clk;
  logic       n_rst;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic       get_rx_data;
  logic       flush;
  logic       clear;
  logic [7:0] rx_data;
  logic [6:0] buffer_occupancy;

  data_buffer dut (
    .clk                  (tb_clk),
    .n_rst                (n_rst),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .get_rx_data          (get_rx_data),
    .flush                (flush),
    .clear                (clear),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [7:0] rx;
    logic [6:0] occ;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  logic [7:0] model_rx;
  int         vectors;
  int         miscompares;
  string      phase;

  // Monitor: one expected response per clocked step, checked mid-cycle.
  always @(negedge tb_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rx_data !== e.rx || buffer_occupancy !== e.occ) begin
        miscompares++;
        $display("FAIL %s: got rx_data=%02h occ=%0d, want rx_data=%02h occ=%0d",
                 phase, rx_data, buffer_occupancy, e.rx, e.occ);
      end
    end
  end

  task automatic step(input logic st, input logic gt, input logic fl, input logic cl,
                      input logic [7:0] d);
    exp_t e;
    bit   got;
    store_rx_packet_data = st;
    get_rx_data          = gt;
    flush                = fl;
    clear                = cl;
    rx_packet_data       = d;
    if (cl) begin
      model_q.delete();
      model_rx = 8'h00;
    end else if (fl) begin
      model_q.delete();
    end else begin
      got = gt && (model_q.size() > 0);
      if (got) model_rx = model_q.pop_front();
      if (st && (model_q.size() < 64 || got)) model_q.push_back(d);
    end
    e.rx  = model_rx;
    e.occ = 7'(model_q.size());
    @(posedge tb_clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    #1;
    store_rx_packet_data = 1'b0;
    get_rx_data          = 1'b0;
    flush                = 1'b0;
    clear                = 1'b0;
    n_rst                = 1'b1;
    model_q.delete();
    model_rx = 8'h00;
    #1;
    vectors++;
    if (rx_data !== 8'h00 || buffer_occupancy !== 7'd0) begin
      miscompares++;
      $display("FAIL async_reset: got rx_data=%02h occ=%0d, want rx_data=00 occ=0",
               rx_data, buffer_occupancy);
    end
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    n_rst = 1'b0;
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    int st_pct;
    vectors              = 0;
    miscompares          = 0;
    model_rx             = 8'h00;
    rx_packet_data       = 8'h00;
    store_rx_packet_data = 1'b0;
    get_rx_data          = 1'b0;
    flush                = 1'b0;
    clear                = 1'b0;
    n_rst                = 1'b1;

    phase = "power_on_reset";
    do_reset();
    step(0, 0, 0, 0, 8'h00);

    phase = "two_bytes";
    step(1, 0, 0, 0, 8'hA5);
    step(1, 0, 0, 0, 8'h3C);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    phase = "fill_full";
    for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 8'(i));
    phase = "store_when_full";
    step(1, 0, 0, 0, 8'hFF);
    step(0, 0, 0, 0, 8'h00);
    phase = "drain_in_order";
    for (int i = 0; i < 64; i++) step(0, 1, 0, 0, 8'h00);
    phase = "get_when_empty";
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);

    phase = "flush";
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(8'h80 + i));
    step(1, 1, 1, 0, 8'h55);
    step(0, 1, 0, 0, 8'h00);
    phase = "clear";
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(8'h90 + i));
    step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 1, 8'h66);
    step(0, 1, 0, 0, 8'h00);

    phase = "wrap_setup";
    for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 56; i++) step(0, 1, 0, 0, 8'h00);
    phase = "wrap_store_get";
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'(8'hC0 + i));
    phase = "wrap_drain";
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'h00);

    phase = "full_store_get";
    for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
    step(1, 1, 0, 0, 8'hEE);
    step(1, 1, 0, 0, 8'hEF);
    step(0, 0, 0, 0, 8'h00);

    phase = "empty_store_get";
    step(0, 0, 1, 0, 8'h00);
    step(1, 1, 0, 0, 8'h77);
    step(0, 1, 0, 0, 8'h00);

    phase = "mid_reset";
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'(8'hD0 + i));
    do_reset();
    step(1, 0, 0, 0, 8'h5A);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      st_pct = ((i / 150) % 2 == 0) ? 80 : 30;
      if (i % 700 == 699) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < st_pct, $urandom_range(0, 99) < 55,
             $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 2, 8'($urandom));
      end
    end

    @(negedge tb_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
